bus_copy_initiator: RTL and testbench
=====================================

# bus_copy_initiator

Bus initiator (DMA-style copy engine) for the SoC's simple select/ready peripheral bus. Given a start pulse, source and destination word addresses and a word count, it issues alternating 32-bit read and write transactions as the bus initiator, copying words one at a time. Each transaction follows the responder-side handshake used by the bus's peripherals, including the idle gap those peripherals need between accesses. A timeout aborts the copy if a responder never answers.

## Interface
- CNT_W, 16, width of word count / words_left
- TIMEOUT_CYCLES, 255, max cycles m_sel may stay high awaiting m_ready (≥2)
- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  32  source byte address; bits [1:0] ignored (forced 0)
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- word_count  in  CNT_W  words to copy; 0 is legal
- busy  out  1  high from cycle after accepted start until done pulse
- done  out  1  one-cycle pulse at completion or abort
- error  out  1  set with done on timeout; cleared on next accepted start
- words_left  out  CNT_W  words not yet written
- m_sel  out  1  transaction select
- m_addr  out  32  transaction address
- m_we  out  4  byte enables; 4'h0 = read, 4'hF = word write
- m_data_o  out  32  write data
- m_data_i  in  32  read data, valid when m_ready high
- m_ready  in  1  responder completion, sampled on rising edge

## Operation
- Reset values: all outputs 0; FSM IDLE; internal addresses, buffer, timeout counter 0.
- States: IDLE, RD, RD_GAP, WR, WR_GAP.
- IDLE: start=1 latches addresses (low bits cleared) and count. Count 0 → done=1 next cycle, error=0, no bus activity, stay IDLE. Else → RD, busy=1, error=0.
- RD: m_sel=1, m_we=0, m_addr=src. Edge with m_ready=1: buffer←m_data_i → RD_GAP.
- RD_GAP: m_sel=0 exactly one cycle → WR.
- WR: m_sel=1, m_we=4'hF, m_addr=dst, m_data_o=buffer. Edge with m_ready=1: words_left−1, src+4, dst+4 → WR_GAP.
- WR_GAP: m_sel=0 one cycle; words_left==0 → IDLE with done=1, busy=0; else → RD.
- Bus outputs registered; m_addr/m_we/m_data_o stable for the whole m_sel-high interval. Outside RD/WR: m_sel=0, m_we=0, m_addr and m_data_o hold last value.
- Address increment modulo 2^32 (0xFFFF_FFFC+4 = 0x0000_0000).
- Timeout: counter cleared on entry to RD/WR, increments each cycle m_sel is high without m_ready. TIMEOUT_CYCLES cycles high with no m_ready → m_sel=0 next cycle, IDLE, done=1, error=1, words_left unchanged. m_ready in the last allowed cycle wins over timeout.
- start while busy: ignored. m_ready outside RD/WR: ignored.

## Timing
- Accepted start at edge N → m_sel high from cycle N+1.
- Responder asserting m_ready in its k-th m_sel-high cycle → access occupies k+1 cycles including gap; one word = k_rd+k_wr+2 cycles.
- With a 3-cycle-latency responder: 8 cycles per word; 1-word copy done pulse 9 cycles after start.
- m_sel drops in the cycle after m_ready is sampled; always ≥1 low cycle between accesses.
- reset asserted mid-transfer: m_sel, busy, done, error drop immediately (asynchronous); nothing resumes after release.

## Structure
- Package bus_copy_pkg: state enum, WE_READ=4'h0, WE_WORD=4'hF, ADDR_STEP=32'd4.
- Sub-module bus_wait_timer: clear/enable/expired counter sized by $clog2(TIMEOUT_CYCLES+1); instantiated once.

## Test plan
- 1 word, src 0x100=0xDEADBEEF, dst 0x200, 3-cycle responder → read 0x100 we=0, gap, write 0x200 we=F data 0xDEADBEEF, done at start+9, error=0.
- 4 words from 0x1000 to 0x2000 → reads 0x1000..0x100C, writes 0x2000..0x200C interleaved, one low m_sel cycle between every access, words_left 4→0.
- word_count=0 → done next cycle, error=0, m_sel never high.
- TIMEOUT_CYCLES=8, responder silent, count=3 → m_sel high exactly 8 cycles, then done=1, error=1, words_left=3.
- reset pulsed during WR of word 2 → m_sel/busy low same cycle; after release no bus activity until new start.
- dst=0xFFFF_FFFC, count=2, plus start pulsed while busy → writes to 0xFFFF_FFFC then 0x0000_0000; extra start ignored.

Source files
------------

// File: rtl/bus_copy_pkg.sv
// bus_copy_pkg: shared types and constants for the bus copy initiator
package bus_copy_pkg;
    typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP} state_t;
    localparam logic [3:0]  WE_READ   = 4'h0;
    localparam logic [3:0]  WE_WORD   = 4'hF;
    localparam logic [31:0] ADDR_STEP = 32'd4;
    localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/bus_wait_timer.sv
// bus_wait_timer: counts select-high cycles without ready, flags the last allowed cycle
module bus_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] cnt;
    assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
    // clear while the bus is idle, count unanswered cycles, hold once expired
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/bus_copy_initiator.sv
// bus_copy_initiator: word-by-word read/write copy engine on the select/ready bus
module bus_copy_initiator
    import bus_copy_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_left,
    output logic             m_sel,
    output logic [31:0]      m_addr,
    output logic [3:0]       m_we,
    output logic [31:0]      m_data_o,
    input  logic [31:0]      m_data_i,
    input  logic             m_ready
);
    state_t      state;
    logic [31:0] src, dst, buffer;
    logic        expired;

    bus_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!m_sel),
        .en      (m_sel && !m_ready),
        .expired (expired)
    );

    // copy sequencer; every bus output is registered and changes only on access entry/exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            src        <= '0;
            dst        <= '0;
            buffer     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            words_left <= '0;
            m_sel      <= 1'b0;
            m_addr     <= '0;
            m_we       <= WE_READ;
            m_data_o   <= '0;
        end else begin
            done <= 1'b0;
            if (m_sel && !m_ready && expired) begin
                state <= IDLE;
                m_sel <= 1'b0;
                m_we  <= WE_READ;
                busy  <= 1'b0;
                done  <= 1'b1;
                error <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        src        <= src_addr & ADDR_MASK;
                        dst        <= dst_addr & ADDR_MASK;
                        words_left <= word_count;
                        error      <= 1'b0;
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state  <= RD;
                            busy   <= 1'b1;
                            m_sel  <= 1'b1;
                            m_we   <= WE_READ;
                            m_addr <= src_addr & ADDR_MASK;
                        end
                    end
                    RD: if (m_ready) begin
                        buffer <= m_data_i;
                        m_sel  <= 1'b0;
                        state  <= RD_GAP;
                    end
                    RD_GAP: begin
                        state    <= WR;
                        m_sel    <= 1'b1;
                        m_we     <= WE_WORD;
                        m_addr   <= dst;
                        m_data_o <= buffer;
                    end
                    WR: if (m_ready) begin
                        words_left <= words_left - CNT_W'(1);
                        src        <= src + ADDR_STEP;
                        dst        <= dst + ADDR_STEP;
                        m_sel      <= 1'b0;
                        m_we       <= WE_READ;
                        state      <= WR_GAP;
                    end
                    WR_GAP: if (words_left == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state  <= RD;
                        m_sel  <= 1'b1;
                        m_we   <= WE_READ;
                        m_addr <= src;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bus_copy_initiator.sv
// tb_bus_copy_initiator: directed checks of the copy engine against a latency-programmable responder
module tb_bus_copy_initiator;
    logic        clk, reset, start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] word_count;
    logic        busy, done, error;
    logic [15:0] words_left;
    logic        m_sel;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_data_o, m_data_i;
    logic        m_ready;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
        int          gap;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] mem [logic [31:0]];
    int          lat, sel_hi, cyc, t0, n_cmp, n_err, lat_v;

    bus_copy_initiator #(.CNT_W(16), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .word_count(word_count), .busy(busy), .done(done), .error(error), .words_left(words_left),
        .m_sel(m_sel), .m_addr(m_addr), .m_we(m_we), .m_data_o(m_data_o), .m_data_i(m_data_i),
        .m_ready(m_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder: answers in the lat-th select-high cycle (lat==0: never), logs each completed access
    initial begin
        int hcnt, lowcnt, gap_now;
        logic [31:0] d;
        hcnt = 0; lowcnt = 1000; gap_now = 0;
        m_ready = 0; m_data_i = 0;
        forever begin
            @(negedge clk);
            if (m_sel) begin
                if (hcnt == 0) begin
                    gap_now = lowcnt;
                    lowcnt = 0;
                end
                hcnt++;
                sel_hi++;
                if (lat != 0 && hcnt == lat) begin
                    if (m_we == 4'hF) begin
                        d = m_data_o;
                        mem[m_addr] = d;
                    end else begin
                        d = mem.exists(m_addr) ? mem[m_addr] : 32'h0;
                        m_data_i = d;
                    end
                    m_ready = 1;
                    txq.push_back('{m_addr, m_we, d, gap_now});
                end else begin
                    m_ready = 0;
                end
            end else begin
                hcnt = 0;
                m_ready = 0;
                lowcnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        word_count = n;
        start = 1;
        t0 = cyc;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string tag, output int lat_out);
        int i;
        i = 0;
        while (!done && i < 300) begin
            @(negedge clk);
            i++;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        lat_out = cyc - t0;
    endtask

    task automatic clear_log();
        txq.delete();
        sel_hi = 0;
    endtask

    initial begin
        int i;
        n_cmp = 0; n_err = 0; sel_hi = 0; lat = 3;
        start = 0; src_addr = 0; dst_addr = 0; word_count = 0;
        reset = 1;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst error", 32'(error), 0);
        check("rst words_left", 32'(words_left), 0);
        check("rst m_sel", 32'(m_sel), 0);
        check("rst m_we", 32'(m_we), 0);
        check("rst m_addr", m_addr, 0);
        check("rst m_data_o", m_data_o, 0);
        reset = 0;
        repeat (2) @(negedge clk);

        // single word, 3-cycle responder
        mem[32'h100] = 32'hDEADBEEF;
        clear_log();
        lat = 3;
        do_start(32'h100, 32'h200, 16'd1);
        check("w1 busy", 32'(busy), 1);
        check("w1 words_left start", 32'(words_left), 1);
        wait_done("w1", lat_v);
        check("w1 latency", 32'(lat_v), 9);
        check("w1 error", 32'(error), 0);
        check("w1 busy at done", 32'(busy), 0);
        check("w1 words_left", 32'(words_left), 0);
        check("w1 ntxn", 32'(txq.size()), 2);
        if (txq.size() == 2) begin
            check("w1 rd addr", txq[0].addr, 32'h100);
            check("w1 rd we", 32'(txq[0].we), 0);
            check("w1 wr addr", txq[1].addr, 32'h200);
            check("w1 wr we", 32'(txq[1].we), 32'hF);
            check("w1 wr data", txq[1].data, 32'hDEADBEEF);
            check("w1 gap", 32'(txq[1].gap), 1);
        end
        @(negedge clk);
        check("w1 done pulse", 32'(done), 0);

        // four words, 1-cycle responder, misaligned addresses get low bits dropped
        for (int k = 0; k < 4; k++) mem[32'h1000 + 32'(4 * k)] = 32'hC0DE_0000 + 32'(k);
        clear_log();
        lat = 1;
        do_start(32'h1001, 32'h2003, 16'd4);
        check("w4 words_left start", 32'(words_left), 4);
        wait_done("w4", lat_v);
        check("w4 latency", 32'(lat_v), 17);
        check("w4 words_left", 32'(words_left), 0);
        check("w4 ntxn", 32'(txq.size()), 8);
        if (txq.size() == 8) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("w4 rd%0d addr", k), txq[2*k].addr, 32'h1000 + 32'(4 * k));
                check($sformatf("w4 rd%0d we", k), 32'(txq[2*k].we), 0);
                check($sformatf("w4 wr%0d addr", k), txq[2*k+1].addr, 32'h2000 + 32'(4 * k));
                check($sformatf("w4 wr%0d we", k), 32'(txq[2*k+1].we), 32'hF);
                check($sformatf("w4 wr%0d data", k), txq[2*k+1].data, 32'hC0DE_0000 + 32'(k));
                check($sformatf("w4 wr%0d gap", k), 32'(txq[2*k+1].gap), 1);
                if (k > 0) check($sformatf("w4 rd%0d gap", k), 32'(txq[2*k].gap), 1);
            end
        end

        // silent responder: timeout after 8 select-high cycles
        clear_log();
        lat = 0;
        do_start(32'h500, 32'h600, 16'd3);
        wait_done("to", lat_v);
        check("to latency", 32'(lat_v), 9);
        check("to error", 32'(error), 1);
        check("to words_left", 32'(words_left), 3);
        check("to m_sel", 32'(m_sel), 0);
        check("to busy", 32'(busy), 0);
        check("to sel_hi", 32'(sel_hi), 8);
        check("to ntxn", 32'(txq.size()), 0);

        // zero-length copy: immediate done, clears previous error, no bus activity
        clear_log();
        lat = 3;
        do_start(32'h700, 32'h800, 16'd0);
        wait_done("z", lat_v);
        check("z latency", 32'(lat_v), 1);
        check("z error", 32'(error), 0);
        check("z busy", 32'(busy), 0);
        repeat (4) @(negedge clk);
        check("z sel_hi", 32'(sel_hi), 0);

        // destination wrap, extra start while busy ignored
        mem[32'h300] = 32'h0BAD_F00D;
        mem[32'h304] = 32'h1234_5678;
        clear_log();
        do_start(32'h300, 32'hFFFF_FFFC, 16'd2);
        repeat (2) @(negedge clk);
        src_addr = 32'h900; dst_addr = 32'hA00; word_count = 16'd5; start = 1;
        @(negedge clk);
        start = 0;
        wait_done("wrap", lat_v);
        check("wrap latency", 32'(lat_v), 17);
        check("wrap words_left", 32'(words_left), 0);
        check("wrap ntxn", 32'(txq.size()), 4);
        if (txq.size() == 4) begin
            check("wrap rd0 addr", txq[0].addr, 32'h300);
            check("wrap wr0 addr", txq[1].addr, 32'hFFFF_FFFC);
            check("wrap wr0 data", txq[1].data, 32'h0BAD_F00D);
            check("wrap rd1 addr", txq[2].addr, 32'h304);
            check("wrap wr1 addr", txq[3].addr, 32'h0000_0000);
            check("wrap wr1 data", txq[3].data, 32'h1234_5678);
        end
        repeat (4) @(negedge clk);
        check("wrap idle sel", 32'(m_sel), 0);

        // asynchronous reset during the second word's write
        mem[32'h3000] = 32'h1111_1111;
        mem[32'h3004] = 32'h2222_2222;
        clear_log();
        do_start(32'h3000, 32'h4000, 16'd3);
        i = 0;
        while (!(txq.size() >= 3 && m_sel && m_we == 4'hF) && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("mr reached wr2", 32'(i < 100), 1);
        #1 reset = 1;
        #1;
        check("mr m_sel", 32'(m_sel), 0);
        check("mr busy", 32'(busy), 0);
        check("mr done", 32'(done), 0);
        check("mr m_we", 32'(m_we), 0);
        repeat (2) @(negedge clk);
        reset = 0;
        clear_log();
        repeat (12) @(negedge clk);
        check("mr sel_hi after", 32'(sel_hi), 0);
        check("mr busy after", 32'(busy), 0);
        check("mr words_left", 32'(words_left), 0);
        check("mr wr1 done", mem.exists(32'h4000) ? mem[32'h4000] : 32'h0, 32'h1111_1111);
        check("mr wr2 absent", 32'(mem.exists(32'h4004)), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
